fpnew_result_buffer: RTL and testbench

Downstream stage of the FPU top wrapper. The wrapper emits each result as a one-cycle `out_valid` pulse and does not honour back-pressure, so this block captures every result (value, status flags, tag) into a small FIFO. It re-presents the results to the core with a proper valid/ready handshake. It also tracks operations issued but not yet completed, and throttles issue so a result can never arrive at a full buffer. Sticky RISC-V fflags accumulate over retired results.

---
 rtl/fpnew_result_buffer.sv | 103 ++++++++++
 tb/tb_fpnew_result_buffer.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/fpnew_result_buffer.sv
// Result buffer behind the FPU wrapper: captures unthrottled result pulses,
// re-presents them with valid/ready and throttles issue via credits.
module fpnew_result_buffer #(
  parameter int unsigned Width    = 64,
  parameter int unsigned TagWidth = 1,
  parameter int unsigned Depth    = 4
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                flush_i,
  input  logic                issue_valid_i,
  input  logic                issue_ready_i,
  output logic                issue_allow_o,
  input  logic                fpu_valid_i,
  input  logic [Width-1:0]    fpu_result_i,
  input  logic [4:0]          fpu_status_i,
  input  logic [TagWidth-1:0] fpu_tag_i,
  output logic                out_valid_o,
  input  logic                out_ready_i,
  output logic [Width-1:0]    result_o,
  output logic [4:0]          status_o,
  output logic [TagWidth-1:0] tag_o,
  output logic [4:0]          fflags_o,
  input  logic                fflags_clr_i,
  output logic                error_o
);

  localparam int unsigned CW = $clog2(Depth + 1);
  localparam int unsigned PW = $clog2(Depth);
  localparam logic [PW-1:0] LastPtr = PW'(Depth - 1);
  localparam logic [CW-1:0] Full = CW'(Depth);

  logic [Width-1:0]    res_q [Depth];
  logic [4:0]          st_q  [Depth];
  logic [TagWidth-1:0] tag_q [Depth];

  logic [PW-1:0] rd_ptr_q, wr_ptr_q;
  logic [CW-1:0] count_q, outst_q;
  logic          issue_fire, push, pop, full, wr_en;
  logic          overflow, underflow;
  logic [CW:0]   credit_used;

  assign issue_fire = issue_valid_i & issue_ready_i;
  assign push       = fpu_valid_i & ~flush_i;
  assign pop        = out_valid_o & out_ready_i & ~flush_i;
  assign full       = (count_q == Full);
  // A pop frees the head slot, so a push into a full buffer still fits.
  assign wr_en      = push & (~full | pop);
  assign overflow   = push & full & ~pop;
  assign underflow  = push & ~issue_fire & (outst_q == '0) & ~flush_i;

  assign credit_used   = {1'b0, outst_q} + {1'b0, count_q};
  assign issue_allow_o = (credit_used < (CW + 1)'(Depth));

  assign out_valid_o = (count_q != '0);
  assign result_o    = out_valid_o ? res_q[rd_ptr_q] : '0;
  assign status_o    = out_valid_o ? st_q[rd_ptr_q]  : '0;
  assign tag_o       = out_valid_o ? tag_q[rd_ptr_q] : '0;

  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      res_q[wr_ptr_q] <= fpu_result_i;
      st_q[wr_ptr_q]  <= fpu_status_i;
      tag_q[wr_ptr_q] <= fpu_tag_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      outst_q  <= '0;
      fflags_o <= '0;
      error_o  <= 1'b0;
    end else begin
      if (overflow || underflow) error_o <= 1'b1;

      if (fflags_clr_i) fflags_o <= '0;
      else if (pop)     fflags_o <= fflags_o | status_o;

      if (flush_i) begin
        rd_ptr_q <= '0;
        wr_ptr_q <= '0;
        count_q  <= '0;
        outst_q  <= '0;
      end else begin
        if (wr_en)
          wr_ptr_q <= (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + 1'b1;
        if (pop)
          rd_ptr_q <= (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + 1'b1;
        if (wr_en && !pop)      count_q <= count_q + 1'b1;
        else if (pop && !wr_en) count_q <= count_q - 1'b1;

        if (issue_fire && !push)
          outst_q <= outst_q + 1'b1;
        else if (push && !issue_fire && outst_q != '0)
          outst_q <= outst_q - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fpnew_result_buffer.sv
// Directed vector bench for fpnew_result_buffer: table-driven sequence plus
// hand-written overflow, underflow and flush sequences.
module tb_fpnew_result_buffer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush, iv, ir, allow, fv;
  logic [63:0] fres;
  logic [4:0]  fst;
  logic [0:0]  ftag;
  logic        ov, ordy;
  logic [63:0] res;
  logic [4:0]  st;
  logic [0:0]  tag;
  logic [4:0]  ff;
  logic        clr, err;

  int nvec = 0;
  int nbad = 0;

  always #5 clk = ~clk;

  fpnew_result_buffer #(.Width(64), .TagWidth(1), .Depth(4)) dut (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
    .issue_valid_i(iv), .issue_ready_i(ir), .issue_allow_o(allow),
    .fpu_valid_i(fv), .fpu_result_i(fres), .fpu_status_i(fst),
    .fpu_tag_i(ftag), .out_valid_o(ov), .out_ready_i(ordy),
    .result_o(res), .status_o(st), .tag_o(tag), .fflags_o(ff),
    .fflags_clr_i(clr), .error_o(err)
  );

  typedef struct {
    logic        fl, iv, ir, fv;
    logic [63:0] res;
    logic [4:0]  st;
    logic        tg, ordy, clr;
    logic        eov;
    logic [63:0] eres;
    logic [4:0]  est;
    logic        etg, eal;
    logic [4:0]  eff;
    logic        eerr;
  } vec_t;

  vec_t tbl[$];

  localparam logic [63:0] R1 = 64'h3FF0_0000_0000_0000;
  localparam logic [63:0] A0 = 64'hA000_0000_0000_0000;
  localparam logic [63:0] A1 = 64'hA111_0000_0000_0001;
  localparam logic [63:0] A2 = 64'hA222_0000_0000_0002;
  localparam logic [63:0] A3 = 64'hA333_0000_0000_0003;
  localparam logic [63:0] A4 = 64'hA444_0000_0000_0004;
  localparam logic [63:0] A5 = 64'hA555_0000_0000_0005;
  localparam logic [63:0] B0 = 64'hB000_0000_0000_00B0;
  localparam logic [63:0] B1 = 64'hB111_0000_0000_00B1;
  localparam logic [63:0] B2 = 64'hB222_0000_0000_00B2;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic drive(logic f, logic i, logic r, logic v,
                       logic [63:0] d, logic [4:0] s, logic t,
                       logic o, logic c);
    flush = f; iv = i; ir = r; fv = v;
    fres = d; fst = s; ftag = t; ordy = o; clr = c;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, '0, '0, 0, 0, 0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  // fl iv ir fv res st tg ordy clr | ov res st tg allow ff err
  initial begin
    tbl.push_back('{0,1,1,0,0,0,0,0,0, 0,0,0,0,1,0,0});
    tbl.push_back('{0,0,0,1,R1,1,1,0,0, 1,R1,1,1,1,0,0});
    tbl.push_back('{0,0,0,0,0,0,0,1,0, 0,0,0,0,1,1,0});
    tbl.push_back('{0,1,1,0,0,0,0,0,0, 0,0,0,0,1,1,0});
    tbl.push_back('{0,1,1,0,0,0,0,0,0, 0,0,0,0,1,1,0});
    tbl.push_back('{0,1,1,0,0,0,0,0,0, 0,0,0,0,1,1,0});
    tbl.push_back('{0,1,1,0,0,0,0,0,0, 0,0,0,0,0,1,0});
    tbl.push_back('{0,0,0,1,A0,0,0,0,0, 1,A0,0,0,0,1,0});
    tbl.push_back('{0,0,0,1,A1,0,1,0,0, 1,A0,0,0,0,1,0});
    tbl.push_back('{0,0,0,1,A2,0,0,0,0, 1,A0,0,0,0,1,0});
    tbl.push_back('{0,0,0,1,A3,0,1,0,0, 1,A0,0,0,0,1,0});
    tbl.push_back('{0,0,0,0,0,0,0,0,0, 1,A0,0,0,0,1,0});
    tbl.push_back('{0,0,0,0,0,0,0,1,0, 1,A1,0,1,1,1,0});
    tbl.push_back('{0,1,1,0,0,0,0,0,0, 1,A1,0,1,0,1,0});
    tbl.push_back('{0,0,0,1,A4,0,1,0,0, 1,A1,0,1,0,1,0});
    tbl.push_back('{0,1,1,0,0,0,0,0,0, 1,A1,0,1,0,1,0});
    tbl.push_back('{0,0,0,1,A5,0,1,1,0, 1,A2,0,0,0,1,0});
    tbl.push_back('{0,0,0,0,0,0,0,1,0, 1,A3,0,1,1,1,0});
    tbl.push_back('{0,0,0,0,0,0,0,1,0, 1,A4,0,1,1,1,0});
    tbl.push_back('{0,0,0,0,0,0,0,1,0, 1,A5,0,1,1,1,0});
    tbl.push_back('{0,0,0,0,0,0,0,1,0, 0,0,0,0,1,1,0});
    tbl.push_back('{0,1,1,0,0,0,0,0,1, 0,0,0,0,1,0,0});
    tbl.push_back('{0,1,1,0,0,0,0,0,0, 0,0,0,0,1,0,0});
    tbl.push_back('{0,1,1,0,0,0,0,0,0, 0,0,0,0,1,0,0});
    tbl.push_back('{0,0,0,1,B0,5'b10000,0,0,0,
                    1,B0,5'b10000,0,1,0,0});
    tbl.push_back('{0,0,0,1,B1,5'b00100,1,1,0,
                    1,B1,5'b00100,1,1,5'b10000,0});
    tbl.push_back('{0,0,0,1,B2,5'b00001,0,1,0,
                    1,B2,5'b00001,0,1,5'b10100,0});
    tbl.push_back('{0,0,0,0,0,0,0,1,1, 0,0,0,0,1,0,0});

    do_reset();
    // Reset state
    chk("rst_ov", 64'(ov), 64'd0);
    chk("rst_allow", 64'(allow), 64'd1);
    chk("rst_ff", 64'(ff), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_res", res, 64'd0);
    chk("rst_st", 64'(st), 64'd0);
    chk("rst_tag", 64'(tag), 64'd0);

    foreach (tbl[i]) begin
      drive(tbl[i].fl, tbl[i].iv, tbl[i].ir, tbl[i].fv, tbl[i].res,
            tbl[i].st, tbl[i].tg, tbl[i].ordy, tbl[i].clr);
      step();
      chk($sformatf("v%0d_ov", i), 64'(ov), 64'(tbl[i].eov));
      chk($sformatf("v%0d_res", i), res, tbl[i].eres);
      chk($sformatf("v%0d_st", i), 64'(st), 64'(tbl[i].est));
      chk($sformatf("v%0d_tag", i), 64'(tag), 64'(tbl[i].etg));
      chk($sformatf("v%0d_allow", i), 64'(allow), 64'(tbl[i].eal));
      chk($sformatf("v%0d_ff", i), 64'(ff), 64'(tbl[i].eff));
      chk($sformatf("v%0d_err", i), 64'(err), 64'(tbl[i].eerr));
    end

    // Overflow: issue and push together, fifth push hits a full buffer
    do_reset();
    for (int k = 0; k < 5; k++) begin
      drive(0, 1, 1, 1, 64'hC0 + 64'(k), 5'(k), 1'(k), 0, 0);
      step();
      chk($sformatf("ovf_err%0d", k), 64'(err), (k == 4) ? 64'd1 : 64'd0);
    end
    for (int k = 0; k < 4; k++) begin
      drive(0, 0, 0, 0, '0, '0, 0, 1, 0);
      chk($sformatf("ovf_res%0d", k), res, 64'hC0 + 64'(k));
      chk($sformatf("ovf_tag%0d", k), 64'(tag), 64'(k % 2));
      step();
    end
    chk("ovf_empty", 64'(ov), 64'd0);
    chk("ovf_ff", 64'(ff), 64'h3);

    // Underflow: completion with nothing outstanding
    do_reset();
    chk("unf_err0", 64'(err), 64'd0);
    drive(0, 0, 0, 1, 64'hDEAD, 5'b00010, 1, 0, 0);
    step();
    chk("unf_err1", 64'(err), 64'd1);
    chk("unf_ov", 64'(ov), 64'd1);

    // Flush mid-stream: 3 buffered, 1 outstanding, fflags 00010
    do_reset();
    for (int k = 0; k < 5; k++) begin
      drive(0, 1, 1, 0, '0, '0, 0, 0, 0);
      step();
    end
    drive(0, 0, 0, 1, 64'hD0, 5'b00010, 0, 0, 0);
    step();
    drive(0, 0, 0, 1, 64'hD1, 5'b00000, 1, 1, 0);
    step();
    chk("fl_ff_pre", 64'(ff), 64'b00010);
    drive(0, 0, 0, 1, 64'hD2, 5'b00000, 0, 0, 0);
    step();
    drive(0, 0, 0, 1, 64'hD3, 5'b00000, 1, 0, 0);
    step();
    chk("fl_allow_pre", 64'(allow), 64'd0);
    chk("fl_head_pre", res, 64'hD1);
    drive(1, 1, 1, 1, 64'hD4, 5'b11111, 0, 1, 0);
    step();
    chk("fl_ov", 64'(ov), 64'd0);
    chk("fl_allow", 64'(allow), 64'd1);
    chk("fl_ff", 64'(ff), 64'b00010);
    chk("fl_err", 64'(err), 64'd0);
    // Outstanding was cleared, so a bare completion is an error
    drive(0, 0, 0, 1, 64'hD5, 5'b00000, 0, 0, 0);
    step();
    chk("fl_outst0", 64'(err), 64'd1);
    chk("fl_new_head", res, 64'hD5);
    idle();
    step();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule
